// File: rtl/encoder_pkg.sv
// Shared 64b/66b definitions: sync header codes and Rx block-lock states.
package encoder_pkg;

  // Sync header codes carried in the 2-bit prefix of each 66-bit block
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block-lock controller states
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_TEST = 2'd1,
    S_SLIP = 2'd2,
    S_WAIT = 2'd3
  } block_lock_state_t;

  // True for the two legal sync headers; 00 and 11 can never start a block
  function automatic logic sync_header_ok(input logic [1:0] header);
    return (header == SYNC_DATA) || (header == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// Rx 64b/66b block-lock controller: hunts for sync-header alignment by
// pulsing slip to the gearbox, then holds lock until too many bad headers
// appear within one test window.
module rx_block_lock
  import encoder_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 32,
  parameter int SLIP_CNT_W     = 16
) (
  input  logic                  i_rxc,
  input  logic                  i_reset,
  input  logic [1:0]            i_rx_header,
  input  logic                  i_rx_valid,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic [SLIP_CNT_W-1:0] o_slip_count
);

  localparam int SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  block_lock_state_t state, next_state;

  logic [SH_W-1:0]   sh_cnt, sh_cnt_next;
  logic [INV_W-1:0]  sh_invalid_cnt, sh_invalid_cnt_next;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              lock_next;
  logic              header_bad;

  assign header_bad = ~sync_header_ok(i_rx_header);

  // State register and window/settle counters
  always_ff @(posedge i_rxc or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_INIT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
    end else begin
      state          <= next_state;
      sh_cnt         <= sh_cnt_next;
      sh_invalid_cnt <= sh_invalid_cnt_next;
      wait_cnt       <= wait_cnt_next;
    end
  end

  // Next-state, counter and lock decisions; loss of lock outranks window end
  always_comb begin
    next_state          = state;
    sh_cnt_next         = sh_cnt;
    sh_invalid_cnt_next = sh_invalid_cnt;
    wait_cnt_next       = wait_cnt;
    lock_next           = o_block_lock;

    case (state)
      S_INIT: begin
        sh_cnt_next         = '0;
        sh_invalid_cnt_next = '0;
        wait_cnt_next       = '0;
        lock_next           = 1'b0;
        next_state          = S_TEST;
      end

      S_TEST: begin
        if (i_rx_valid) begin
          sh_cnt_next         = sh_cnt + SH_W'(1);
          sh_invalid_cnt_next = sh_invalid_cnt + INV_W'(header_bad);
          if (!o_block_lock) begin
            if (header_bad) begin
              next_state = S_SLIP;
            end else if (sh_cnt_next == SH_LAST) begin
              lock_next           = 1'b1;
              sh_cnt_next         = '0;
              sh_invalid_cnt_next = '0;
            end
          end else if (sh_invalid_cnt_next == INV_LAST) begin
            lock_next  = 1'b0;
            next_state = S_SLIP;
          end else if (sh_cnt_next == SH_LAST) begin
            sh_cnt_next         = '0;
            sh_invalid_cnt_next = '0;
          end
        end
      end

      S_SLIP: begin
        sh_cnt_next         = '0;
        sh_invalid_cnt_next = '0;
        wait_cnt_next       = '0;
        lock_next           = 1'b0;
        next_state          = S_WAIT;
      end

      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt_next       = '0;
          sh_cnt_next         = '0;
          sh_invalid_cnt_next = '0;
          next_state          = S_TEST;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end

      default: begin
        next_state = S_INIT;
      end
    endcase
  end

  // Registered outputs: slip pulses in the S_SLIP cycle, count saturates
  always_ff @(posedge i_rxc or posedge i_reset) begin
    if (i_reset) begin
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_slip_count <= '0;
    end else begin
      o_slip       <= (next_state == S_SLIP) && (state != S_SLIP);
      o_block_lock <= lock_next;
      if ((next_state == S_SLIP) && (state != S_SLIP) && (o_slip_count != '1)) begin
        o_slip_count <= o_slip_count + SLIP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: a header-level behavioural model
// is compared against two DUTs (default and 4-bit slip counter) each cycle,
// plus hand-computed literal checkpoints along a directed scenario.
module tb_rx_block_lock;

  localparam int CNT_MAX = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rx_header = 2'b00;
  logic        rx_valid = 1'b0;
  logic        slip, block_lock;
  logic [15:0] slip_count;
  logic        slip_s, block_lock_s;
  logic [3:0]  slip_count_s;

  int n_checks = 0;
  int n_fail   = 0;
  bit running  = 1'b1;

  // Model state: lock flag, window tallies, edges still blind, total slips
  bit m_lock  = 1'b0;
  bit m_slip  = 1'b0;
  int m_slips = 0;
  int m_blind = 1;
  int m_seen  = 0;
  int m_bad   = 0;

  rx_block_lock dut (
    .i_rxc        (clk),
    .i_reset      (rst),
    .i_rx_header  (rx_header),
    .i_rx_valid   (rx_valid),
    .o_slip       (slip),
    .o_block_lock (block_lock),
    .o_slip_count (slip_count)
  );

  rx_block_lock #(.SLIP_CNT_W(4)) dut_sat (
    .i_rxc        (clk),
    .i_reset      (rst),
    .i_rx_header  (rx_header),
    .i_rx_valid   (rx_valid),
    .o_slip       (slip_s),
    .o_block_lock (block_lock_s),
    .o_slip_count (slip_count_s)
  );

  always #5 clk = ~clk;

  // Header-level model: after reset or a slip a fixed number of edges see
  // nothing; otherwise each qualified header is tallied against the window
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lock = 1'b0; m_slip = 1'b0; m_slips = 0;
      m_blind = 1; m_seen = 0; m_bad = 0;
    end else begin
      m_slip = 1'b0;
      if (m_blind > 0) begin
        m_blind--;
      end else if (rx_valid) begin
        bit good;
        bit lose;
        good = (rx_header == 2'b01) || (rx_header == 2'b10);
        m_seen++;
        if (!good) m_bad++;
        lose = m_lock ? (m_bad >= INV_MAX) : !good;
        if (lose) begin
          m_lock = 1'b0; m_slip = 1'b1; m_slips++;
          m_seen = 0; m_bad = 0; m_blind = WAIT + 1;
        end else if (m_seen == CNT_MAX) begin
          m_lock = 1'b1; m_seen = 0; m_bad = 0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (running) begin
      check_output("slip", 32'(slip), 32'(m_slip));
      check_output("lock", 32'(block_lock), 32'(m_lock));
      check_output("slip_count", 32'(slip_count), 32'(m_slips > 65535 ? 65535 : m_slips));
      check_output("slip_s", 32'(slip_s), 32'(m_slip));
      check_output("lock_s", 32'(block_lock_s), 32'(m_lock));
      check_output("slip_count_s", 32'(slip_count_s), 32'(m_slips > 15 ? 15 : m_slips));
    end
  end

  // One header per call, sampled on the next rising edge
  task automatic apply_stimulus(input logic [1:0] header, input logic valid);
    rx_header = header;
    rx_valid  = valid;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(2'b00, 1'b0);
  endtask

  task automatic good_headers(input int n);
    for (int i = 0; i < n; i++) apply_stimulus((i % 2) ? 2'b10 : 2'b01, 1'b1);
  endtask

  // After a slip pulse: ride out the blind edges with junk, then relock
  task automatic recover();
    for (int i = 0; i < WAIT + 1; i++) apply_stimulus(2'b00, 1'b1);
    good_headers(CNT_MAX - 1);
    check_output("relock_pre", 32'(block_lock), 32'd0);
    good_headers(1);
    check_output("relock", 32'(block_lock), 32'd1);
  endtask

  initial begin
    // Reset values
    @(posedge clk);
    #1;
    check_output("rst_slip", 32'(slip), 32'd0);
    check_output("rst_lock", 32'(block_lock), 32'd0);
    check_output("rst_count", 32'(slip_count), 32'd0);
    rst = 1'b0;
    apply_stimulus(2'b00, 1'b0);

    // Clean lock on the 64th header
    good_headers(CNT_MAX - 1);
    check_output("clean_lock_63", 32'(block_lock), 32'd0);
    good_headers(1);
    check_output("clean_lock_64", 32'(block_lock), 32'd1);
    check_output("clean_count", 32'(slip_count), 32'd0);

    // Hunt: bad header on the 10th valid cycle
    do_reset();
    good_headers(9);
    apply_stimulus(2'b11, 1'b1);
    check_output("hunt_slip", 32'(slip), 32'd1);
    check_output("hunt_count", 32'(slip_count), 32'd1);
    apply_stimulus(2'b00, 1'b1);
    check_output("hunt_slip_once", 32'(slip), 32'd0);
    for (int i = 0; i < WAIT; i++) apply_stimulus(2'b11, 1'b1);
    check_output("hunt_wait_blind", 32'(slip_count), 32'd1);
    good_headers(CNT_MAX - 1);
    check_output("hunt_lock_pre", 32'(block_lock), 32'd0);
    good_headers(1);
    check_output("hunt_lock", 32'(block_lock), 32'd1);

    // Tolerated: 15 bad at window end, then 15 bad at next window start
    good_headers(CNT_MAX - 15);
    for (int i = 0; i < 15; i++) apply_stimulus(2'b00, 1'b1);
    check_output("tol_lock_w1", 32'(block_lock), 32'd1);
    for (int i = 0; i < 15; i++) apply_stimulus(2'b11, 1'b1);
    good_headers(CNT_MAX - 15);
    check_output("tol_lock_w2", 32'(block_lock), 32'd1);
    check_output("tol_count", 32'(slip_count), 32'd1);

    // Loss of lock: 16 bad within 40 headers
    good_headers(24);
    for (int i = 0; i < 15; i++) apply_stimulus(2'b00, 1'b1);
    check_output("loss_hold_15", 32'(block_lock), 32'd1);
    apply_stimulus(2'b11, 1'b1);
    check_output("loss_lock", 32'(block_lock), 32'd0);
    check_output("loss_slip", 32'(slip), 32'd1);
    check_output("loss_count", 32'(slip_count), 32'd2);
    recover();

    // Loss on the 64th header of the window beats window completion
    good_headers(CNT_MAX - INV_MAX);
    for (int i = 0; i < INV_MAX; i++) apply_stimulus(2'b00, 1'b1);
    check_output("prio_lock", 32'(block_lock), 32'd0);
    check_output("prio_slip", 32'(slip), 32'd1);
    check_output("prio_count", 32'(slip_count), 32'd3);
    recover();

    // Valid gating: 64 qualified headers at 50% duty
    do_reset();
    for (int i = 0; i < 126; i++) begin
      if (i % 2 == 0) apply_stimulus((i % 4 == 0) ? 2'b01 : 2'b10, 1'b1);
      else apply_stimulus(2'b11, 1'b0);
    end
    check_output("gate_lock_63", 32'(block_lock), 32'd0);
    apply_stimulus(2'b01, 1'b1);
    check_output("gate_lock_64", 32'(block_lock), 32'd1);
    check_output("gate_count", 32'(slip_count), 32'd0);

    // Continuous slips: 4-bit counter saturates at 15
    do_reset();
    for (int s = 1; s <= 20; s++) begin
      apply_stimulus(2'b11, 1'b1);
      if (s == 15) check_output("sat_at_15", 32'(slip_count_s), 32'd15);
      if (s == 16) check_output("sat_hold", 32'(slip_count_s), 32'd15);
      for (int i = 0; i < WAIT + 1; i++) apply_stimulus(2'b11, 1'b1);
    end
    check_output("sat_main", 32'(slip_count), 32'd20);
    check_output("sat_small", 32'(slip_count_s), 32'd15);

    // Async reset during a slip pulse
    apply_stimulus(2'b11, 1'b1);
    check_output("areset_pre_slip", 32'(slip), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_output("areset_slip", 32'(slip), 32'd0);
    check_output("areset_count", 32'(slip_count), 32'd0);
    check_output("areset_count_s", 32'(slip_count_s), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(2'b00, 1'b0);

    // Async reset in the middle of the settle wait
    good_headers(9);
    apply_stimulus(2'b00, 1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(2'b01, 1'b1);
    check_output("wait_pre_count", 32'(slip_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("wreset_count", 32'(slip_count), 32'd0);
    check_output("wreset_lock", 32'(block_lock), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply_stimulus(2'b00, 1'b0);
    good_headers(CNT_MAX);
    check_output("post_reset_lock", 32'(block_lock), 32'd1);

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
